// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types: address/instruction widths and the {pc, instr} entry
// handed from fetch to decode.
package fetch_queue_pkg;

  localparam int unsigned AW = 16;
  localparam int unsigned IW = 16;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t FetchEntryRst = '0;

endpackage

// File: rtl/fetch_fifo_mem.sv
// DEPTH x WIDTH register array for the fetch queue: one write port, one
// asynchronous read port. Contents reset to zero so the head reads 0 after reset.
module fetch_fifo_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = AW + IW,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= WIDTH'(FetchEntryRst);
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues one imem read per credit, captures the word one
// cycle later with its PC, and presents {pc, instr} to decode via valid/ready.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = fetch_queue_pkg::AW,
  parameter int unsigned IW    = fetch_queue_pkg::IW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          pc_in,
  output logic                   pc_en,
  output logic                   imem_rd_en,
  output logic [AW-1:0]          imem_addr,
  input  logic [IW-1:0]          imem_rdata,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW-1:0]          out_pc,
  output logic [IW-1:0]          out_instr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_queue: DEPTH must be a power of two, at least 2");
  end

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             inflight_q;
  logic             squash_q, squash_d;
  logic [AW-1:0]    issued_pc_q;
  logic             credit;
  logic             push;
  logic             pop;
  logic [AW+IW-1:0] rd_data;

  // Conservative credit: the in-flight return must always find a free slot, and a
  // same-cycle pop is not counted so the issue path never depends on out_ready.
  assign credit     = (32'(count_q) + 32'(inflight_q)) < DEPTH;
  assign imem_rd_en = reset & ~flush & credit;
  assign pc_en      = imem_rd_en;
  assign imem_addr  = pc_in;

  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready & ~flush;
  assign push       = inflight_q & ~squash_q & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    squash_d = squash_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      squash_d = 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
      // A fresh issue after a redirect belongs to the new stream.
      if (imem_rd_en) begin
        squash_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      squash_q    <= 1'b0;
      issued_pc_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      inflight_q  <= imem_rd_en;
      squash_q    <= squash_d;
      issued_pc_q <= pc_in;
    end
  end

  fetch_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(AW + IW)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push),
    .wr_addr(wr_ptr_q),
    .wr_data({issued_pc_q, imem_rdata}),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );

  assign out_pc    = rd_data[AW+IW-1:IW];
  assign out_instr = rd_data[IW-1:0];
  assign count     = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && count_q == CW'(DEPTH)));

  a_full_no_issue: assert property (@(posedge clk) disable iff (!reset)
    (count_q == CW'(DEPTH)) |-> !imem_rd_en);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model of the
// fetch stream, with a PC register and 1-cycle instruction memory as environment.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 16;
  localparam int unsigned IW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_in;
  logic          pc_en;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic [2:0]    count;

  fetch_queue #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .IW   (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .pc_en     (pc_en),
    .imem_rd_en(imem_rd_en),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  ent_t          mq[$];
  logic          pend;
  logic [AW-1:0] pend_pc;
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_pops   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic step(input logic rdy, input logic fl, input logic [AW-1:0] tgt);
    logic          exp_en;
    logic          mem_en;
    logic          pcen_s;
    logic [AW-1:0] mem_addr;
    out_ready = rdy;
    flush     = fl;
    #1;
    exp_en = !fl && ((mq.size() + (pend ? 1 : 0)) < DEPTH);
    check_eq("imem_rd_en", 32'(imem_rd_en), 32'(exp_en));
    check_eq("pc_en", 32'(pc_en), 32'(exp_en));
    if (exp_en) check_eq("imem_addr", 32'(imem_addr), 32'(pc_in));
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("out_pc", 32'(out_pc), 32'(mq[0].pc));
      check_eq("out_instr", 32'(out_instr), 32'(mq[0].instr));
    end
    if (fl) begin
      mq.delete();
      pend = 1'b0;
    end else begin
      if (mq.size() != 0 && rdy) begin
        void'(mq.pop_front());
        n_pops++;
      end
      if (pend) mq.push_back('{pc: pend_pc, instr: pend_pc ^ 16'hA5A5});
      pend    = exp_en;
      pend_pc = pc_in;
    end
    mem_en   = imem_rd_en;
    mem_addr = imem_addr;
    pcen_s   = pc_en;
    @(posedge clk);
    #1;
    imem_rdata = mem_en ? (mem_addr ^ 16'hA5A5) : IW'($urandom);
    if (fl) pc_in = tgt;
    else if (pcen_s) pc_in = pc_in + 16'd1;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    pc_in      = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    imem_rdata = '0;
    pend       = 1'b0;
    pend_pc    = '0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_rd_en", 32'(imem_rd_en), 32'd0);
      check_eq("rst_pc_en", 32'(pc_en), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_out_pc", 32'(out_pc), 32'd0);
      check_eq("rst_out_instr", 32'(out_instr), 32'd0);
    end
    reset = 1'b1;

    // Stream with out_ready=1
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check_eq("first_valid", 32'(out_valid), 32'd1);
    check_eq("first_pc", 32'(out_pc), 32'h0000);
    check_eq("first_instr", 32'(out_instr), 32'hA5A5);
    step(1'b1, 1'b0, '0);
    check_eq("second_pc", 32'(out_pc), 32'h0001);
    check_eq("second_instr", 32'(out_instr), 32'hA5A4);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Backpressure to full from a redirect to 0
    step(1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_pc_en", 32'(pc_en), 32'd0);
    check_eq("full_pc_hold", 32'(pc_in), 32'h0004);
    check_eq("full_head", 32'(out_pc), 32'h0000);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

    // Simultaneous push and pop at count=2
    for (int i = 0; i < 10 && count != 3'd2; i++) step(1'b0, 1'b0, '0);
    check_eq("reach_two", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, '0);
      check_eq("hold_two", 32'(count), 32'd2);
    end

    // Flush with fetch in flight
    step(1'b1, 1'b1, 16'h0010);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 16'h0100);
    check_eq("flush_count", 32'(count), 32'd0);
    for (int i = 0; i < 6 && !out_valid; i++) step(1'b1, 1'b0, '0);
    check_eq("redirect_valid", 32'(out_valid), 32'd1);
    check_eq("redirect_pc", 32'(out_pc), 32'h0100);
    check_eq("redirect_instr", 32'(out_instr), 32'h0100 ^ 32'hA5A5);

    // Back-to-back flushes
    step(1'b1, 1'b1, 16'h0200);
    step(1'b1, 1'b1, 16'h0300);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    // Async reset mid-stream at count=3
    for (int i = 0; i < 12 && count != 3'd3; i++) step(1'b0, 1'b0, '0);
    check_eq("reach_three", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_pc_en", 32'(pc_en), 32'd0);
    check_eq("arst_rd_en", 32'(imem_rd_en), 32'd0);
    check_eq("arst_count", 32'(count), 32'd0);
    mq.delete();
    pend  = 1'b0;
    pc_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Random out_ready across pointer wraps
    n_pops = 0;
    for (int i = 0; i < 500 && n_pops < 37; i++) step(1'(($urandom_range(0, 1))), 1'b0, '0);
    check_eq("random_pops", 32'(n_pops >= 37), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Each cycle it may issue a read of instruction memory at the current PC, then capture the returned word together with its PC.
- Holds {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Throttles the PC with pc_en; a flush drops everything buffered or in flight after a redirect.

Parameters:
- DEPTH, 4, number of {pc, instr} entries; power of two, at least 2.
- AW, 16, PC / instruction-memory address width.
- IW, 16, instruction word width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- pc_in  input  AW  current PC from the program counter register.
- pc_en  output  1  high = PC register may advance by 1 this cycle.
- imem_rd_en  output  1  instruction memory read strobe.
- imem_addr  output  AW  read address; equals pc_in when imem_rd_en=1.
- imem_rdata  input  IW  read data; valid exactly 1 cycle after imem_rd_en.
- flush  input  1  redirect: discard all queued and in-flight fetches.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  AW  PC of the head entry.
- out_instr  output  IW  instruction of the head entry.
- count  output  log2(DEPTH)+1  current occupancy, for debug and performance counters.

Behaviour:
- Reset (reset=0, asynchronous): count=0, rd/wr pointers=0, inflight=0, out_valid=0, pc_en=0, imem_rd_en=0. out_pc and out_instr read 0.
- Issue:
  - imem_rd_en = reset_deasserted & ~flush & (count + inflight < DEPTH).
  - pc_en = imem_rd_en; the PC advances exactly once per issued fetch.
  - The limit is conservative: a same-cycle pop does not free a slot for issue.
- In flight:
  - Register inflight <= imem_rd_en; latch issued_pc <= pc_in.
  - At most one fetch is in flight.
- Capture:
  - When inflight=1 and no squash applies, write {issued_pc, imem_rdata} at wr_ptr on that edge.
  - Fetch-to-out_valid latency is 2 cycles: issue at cycle N, data at N+1, out_valid at N+2. Sustained throughput is 1 instruction per cycle when out_ready=1.
- Output:
  - out_valid = (count != 0).
  - out_pc and out_instr are driven from mem[rd_ptr]; no combinational path from imem_rdata.
  - Pop occurs when out_valid & out_ready.
  - out_pc and out_instr stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap: pointers wrap modulo DEPTH.
- Full: count=DEPTH implies imem_rd_en=0. The credit rule guarantees the in-flight return always has a slot; overflow is impossible and is an assertion target.
- Empty: out_valid=0; out_ready is ignored.
- Flush (synchronous, evaluated at the clock edge):
  - count <= 0, pointers <= 0.
  - The in-flight return is squashed: the data arriving the next cycle is not written (squash flag set by flush, consumed with inflight).
  - No pop occurs in the flush cycle, even if out_ready=1.
  - imem_rd_en=0 and pc_en=0 during the flush cycle, so the PC stage loads the redirect target undisturbed.
  - Fetch resumes the following cycle from the new pc_in.
  - Back-to-back flushes behave the same way.
- Reset asserted mid-operation: state clears immediately. The first issue occurs in the first cycle after deassertion.
- Address arithmetic: none inside the block; all PC arithmetic stays in the PC adder.

Decomposition:
- Shared package: AW, IW, the reset-value constant (all zeros), and the {pc, instr} fetch-entry packed typedef, used by decode as well.
- One natural sub-module: fetch_fifo_mem, the DEPTH x (AW+IW) register array with write port and read port. Pointers, count, inflight/squash and the credit logic stay in fetch_queue.

Test Plan:
- Reset then stream:
  - Stimulus: reset low 3 cycles; pc_in starts at 0x0000 and follows pc_en; memory returns instr = addr ^ 0xA5A5; out_ready=1.
  - Required response: imem_rd_en rises in the first cycle after deassertion; out_valid rises 2 cycles later with out_pc=0x0000, out_instr=0xA5A5; then one entry per cycle, 0x0001/0xA5A4, and so on.
- Backpressure to full:
  - Stimulus: out_ready=0.
  - Required response: after 4 issues, count=4, pc_en=0, and pc_in holds at 0x0004; out_pc stays 0x0000. After out_ready rises, entries drain in order 0x0000..0x0003 and issue resumes at 0x0004.
- Simultaneous push and pop:
  - Stimulus: count=2, out_ready=1, steady fetch.
  - Required response: count stays 2 across 10 cycles; the popped sequence has no gaps or duplicates.
- Flush with fetch in flight:
  - Stimulus: assert flush 1 cycle after issuing pc=0x0010; then pc_in=0x0100.
  - Required response: the return for 0x0010 is not enqueued and count=0 after flush; the next out_pc is 0x0100.
- Async reset mid-stream:
  - Stimulus: pull reset low between clock edges while count=3.
  - Required response: out_valid, pc_en and imem_rd_en go to 0 immediately, without waiting for a clock edge.
- Pointer wrap:
  - Stimulus: run 37 instructions with random out_ready.
  - Required response: output order matches issue order exactly; count never exceeds 4.
